fifo_sync_lvl: RTL and testbench

- Parametrised single-clock FIFO. Next generation of the team's FIFO macros, for same-domain buffering.
- Adds the following over the dual-clock converter:
  - exact fill level output
  - run-time almost-full / almost-empty thresholds
  - synchronous flush
  - registered read-data valid strobe
- Storage is an internal 2^ADDW x DATW register array. Write and read share one clock, so no pointer synchronisation is needed.

---
 rtl/fifo_sync_lvl.sv | 131 +++++++++++++
 tb/tb_fifo_sync_lvl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_lvl.sv
// fifo_sync_lvl: single-clock FIFO with fill level, run-time almost-full and
// almost-empty thresholds, synchronous flush and a registered read strobe.
// Ports:
//   clk, rst_n (async, active-low), flush (sync clear, highest priority)
//   wren/wdata in; wfull, wafull (level >= afull_thr) out
//   rden in; rdata (registered), rvalid (1-cycle strobe), rempty,
//   raempty (level <= aempty_thr) out
//   afull_thr, aempty_thr in (0..DEPTH); level out (0..DEPTH)
// Optional: define FIFO_SYNC_ERR_EN to add sticky ovf/udf error flags.
module fifo_sync_lvl #(
   parameter int ADDW = 4,
   parameter int DATW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            wren,
   input  logic [DATW-1:0] wdata,
   output logic            wfull,
   output logic            wafull,
   input  logic            rden,
   output logic [DATW-1:0] rdata,
   output logic            rvalid,
   output logic            rempty,
   output logic            raempty,
   input  logic [ADDW:0]   afull_thr,
   input  logic [ADDW:0]   aempty_thr,
   output logic [ADDW:0]   level
`ifdef FIFO_SYNC_ERR_EN
   ,
   output logic            ovf,
   output logic            udf
`endif
);

   localparam int DEPTH = 1 << ADDW;
   localparam logic [ADDW:0]   LVL_ONE  = {{ADDW{1'b0}}, 1'b1};
   localparam logic [ADDW:0]   LVL_FULL = {1'b1, {ADDW{1'b0}}};
   localparam logic [ADDW-1:0] PTR_ONE  = {{(ADDW-1){1'b0}}, 1'b1};

   logic [DATW-1:0] mem [DEPTH];
   logic [ADDW-1:0] wptr;
   logic [ADDW-1:0] rptr;
   logic [ADDW:0]   level_nxt;
   logic            wa;
   logic            ra;

   // Accepts are gated by the registered flags, which already reflect
   // the current level, so a full/empty FIFO still takes the opposite op.
   assign wa = wren & ~wfull & ~flush;
   assign ra = rden & ~rempty & ~flush;

   always_comb begin
      level_nxt = level;
      if (flush)
         level_nxt = '0;
      else if (wa & ~ra)
         level_nxt = level + LVL_ONE;
      else if (ra & ~wa)
         level_nxt = level - LVL_ONE;
   end

   // Storage needs no reset; contents are only observed after a write.
   always_ff @(posedge clk) begin
      if (wa)
         mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wa)
            wptr <= wptr + PTR_ONE;
         if (ra)
            rptr <= rptr + PTR_ONE;
      end
   end

   // Flags are derived from level_nxt so they move in the same cycle
   // as the level register itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level   <= '0;
         wfull   <= 1'b0;
         rempty  <= 1'b1;
         wafull  <= 1'b0;
         raempty <= 1'b1;
      end else begin
         level   <= level_nxt;
         wfull   <= (level_nxt == LVL_FULL);
         rempty  <= (level_nxt == '0);
         wafull  <= (level_nxt >= afull_thr);
         raempty <= (level_nxt <= aempty_thr);
      end
   end

   // rdata holds across flush and idle cycles; only rvalid drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= ra;
         if (ra)
            rdata <= mem[rptr];
      end
   end

`ifdef FIFO_SYNC_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else if (flush) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (wren & wfull)
            ovf <= 1'b1;
         if (rden & rempty)
            udf <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_sync_lvl.sv
// tb_fifo_sync_lvl: self-checking bench for fifo_sync_lvl using a
// queue-based reference model, a vector table and directed sequences.
module tb_fifo_sync_lvl;

   localparam int ADDW  = 4;
   localparam int DATW  = 8;
   localparam int DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic            wren = 1'b0;
   logic            rden = 1'b0;
   logic [DATW-1:0] wdata = '0;
   logic [ADDW:0]   afull_thr = 5'd16;
   logic [ADDW:0]   aempty_thr = 5'd0;
   logic            wfull, wafull, rvalid, rempty, raempty;
   logic [DATW-1:0] rdata;
   logic [ADDW:0]   level;
`ifdef FIFO_SYNC_ERR_EN
   logic            ovf, udf;
`endif

   fifo_sync_lvl #(.ADDW(ADDW), .DATW(DATW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .wren(wren), .wdata(wdata), .wfull(wfull), .wafull(wafull),
      .rden(rden), .rdata(rdata), .rvalid(rvalid),
      .rempty(rempty), .raempty(raempty),
      .afull_thr(afull_thr), .aempty_thr(aempty_thr), .level(level)
`ifdef FIFO_SYNC_ERR_EN
      , .ovf(ovf), .udf(udf)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // reference model state
   logic [7:0] q[$];
   logic [7:0] m_rdata;
   logic       m_rvalid, m_wafull, m_raempty, m_ovf, m_udf;

   typedef struct {
      logic       fl, wr, rd;
      logic [7:0] wd;
      logic [4:0] lvl;
      logic       ep, fu, af, ae, rv;
      logic [7:0] rdd;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_rdata = '0;
      m_rvalid = 1'b0;
      m_wafull = 1'b0;
      m_raempty = 1'b1;
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   task automatic model_update();
      int n;
      bit wa, ra;
      n = q.size();
      wa = wren && (n < DEPTH) && !flush;
      ra = rden && (n > 0) && !flush;
      if (flush) begin
         q.delete();
         m_rvalid = 1'b0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         if (wren && n == DEPTH) m_ovf = 1'b1;
         if (rden && n == 0) m_udf = 1'b1;
         m_rvalid = ra;
         if (ra) m_rdata = q.pop_front();
         if (wa) q.push_back(wdata);
      end
      m_wafull = (q.size() >= int'(afull_thr));
      m_raempty = (q.size() <= int'(aempty_thr));
   endtask

   task automatic cmp_model();
      chk("level", 32'(level), 32'(q.size()));
      chk("rempty", 32'(rempty), 32'(q.size() == 0));
      chk("wfull", 32'(wfull), 32'(q.size() == DEPTH));
      chk("wafull", 32'(wafull), 32'(m_wafull));
      chk("raempty", 32'(raempty), 32'(m_raempty));
      chk("rvalid", 32'(rvalid), 32'(m_rvalid));
      chk("rdata", 32'(rdata), 32'(m_rdata));
`ifdef FIFO_SYNC_ERR_EN
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("udf", 32'(udf), 32'(m_udf));
`endif
   endtask

   // apply current inputs for one clock, then compare against the model
   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      cmp_model();
   endtask

   task automatic drive(logic f, logic w, logic r, logic [7:0] d);
      flush = f;
      wren = w;
      rden = r;
      wdata = d;
   endtask

   initial begin
      tbl[0] = '{0, 1, 0, 8'h11, 5'd1, 0, 0, 0, 1, 0, 8'h00};
      tbl[1] = '{0, 1, 0, 8'h22, 5'd2, 0, 0, 0, 0, 0, 8'h00};
      tbl[2] = '{0, 1, 1, 8'h33, 5'd2, 0, 0, 0, 0, 1, 8'h11};
      tbl[3] = '{0, 1, 0, 8'h44, 5'd3, 0, 0, 1, 0, 0, 8'h11};
      tbl[4] = '{0, 0, 1, 8'h00, 5'd2, 0, 0, 0, 0, 1, 8'h22};
      tbl[5] = '{0, 0, 0, 8'h00, 5'd2, 0, 0, 0, 0, 0, 8'h22};
      tbl[6] = '{1, 1, 1, 8'h99, 5'd0, 1, 0, 0, 1, 0, 8'h22};
      tbl[7] = '{0, 0, 1, 8'h00, 5'd0, 1, 0, 0, 1, 0, 8'h22};

      model_reset();
      #12;
      chk("rst_level", 32'(level), 0);
      chk("rst_rempty", 32'(rempty), 1);
      chk("rst_wfull", 32'(wfull), 0);
      chk("rst_wafull", 32'(wafull), 0);
      chk("rst_raempty", 32'(raempty), 1);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rdata", 32'(rdata), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // vector table
      afull_thr = 5'd3;
      aempty_thr = 5'd1;
      drive(0, 0, 0, 0);
      step();
      foreach (tbl[i]) begin
         drive(tbl[i].fl, tbl[i].wr, tbl[i].rd, tbl[i].wd);
         step();
         chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].lvl));
         chk($sformatf("v%0d_rempty", i), 32'(rempty), 32'(tbl[i].ep));
         chk($sformatf("v%0d_wfull", i), 32'(wfull), 32'(tbl[i].fu));
         chk($sformatf("v%0d_wafull", i), 32'(wafull), 32'(tbl[i].af));
         chk($sformatf("v%0d_raempty", i), 32'(raempty), 32'(tbl[i].ae));
         chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
         chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(tbl[i].rdd));
      end

      // fill to full, overflow write dropped
      afull_thr = 5'd16;
      aempty_thr = 5'd0;
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 0, 8'(i));
         step();
         chk("fill_level", 32'(level), 32'(i + 1));
         chk("fill_wfull", 32'(wfull), 32'(i == 15));
      end
      drive(0, 1, 0, 8'hAA);
      step();
      chk("ovw_level", 32'(level), 16);

      // drain in order, extra read gives nothing
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 1, 0);
         step();
         chk("drain_rvalid", 32'(rvalid), 1);
         chk("drain_rdata", 32'(rdata), 32'(i));
      end
      chk("drain_rempty", 32'(rempty), 1);
      drive(0, 0, 1, 0);
      step();
      chk("xrd_rvalid", 32'(rvalid), 0);
      chk("xrd_level", 32'(level), 0);

      // level 8, simultaneous wr/rd across pointer wrap
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 0, 8'(8'h30 + i));
         step();
      end
      for (int i = 0; i < 20; i++) begin
         drive(0, 1, 1, 8'(8'h40 + i));
         step();
         chk("wrap_level", 32'(level), 8);
         chk("wrap_rdata", 32'(rdata),
             (i < 8) ? 32'(8'h30 + i) : 32'(8'h40 + i - 8));
      end
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 1, 0);
         step();
         chk("wrap_tail", 32'(rdata), 32'(8'h4C + i));
      end

      // empty: simultaneous wr/rd, no fall-through
      drive(0, 1, 1, 8'h5A);
      step();
      chk("nft_rvalid", 32'(rvalid), 0);
      chk("nft_level", 32'(level), 1);
      chk("nft_rempty", 32'(rempty), 0);
      drive(0, 0, 1, 0);
      step();
      chk("nft_rdata", 32'(rdata), 32'h5A);
      chk("nft_rv2", 32'(rvalid), 1);

      // thresholds on fill and drain
      afull_thr = 5'd12;
      aempty_thr = 5'd3;
      drive(0, 0, 0, 0);
      step();
      for (int l = 1; l <= 13; l++) begin
         drive(0, 1, 0, 8'(l));
         step();
         chk("thr_up_ae", 32'(raempty), 32'(l <= 3));
         chk("thr_up_af", 32'(wafull), 32'(l >= 12));
      end
      for (int l = 12; l >= 0; l--) begin
         drive(0, 0, 1, 0);
         step();
         chk("thr_dn_ae", 32'(raempty), 32'(l <= 3));
         chk("thr_dn_af", 32'(wafull), 32'(l >= 12));
      end

      // full + overflow attempt, drain to 10, then flush with wr/rd
      afull_thr = 5'd16;
      aempty_thr = 5'd0;
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 0, 8'(8'h80 + i));
         step();
      end
      drive(0, 1, 0, 8'hEE);
      step();
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 1, 0);
         step();
      end
      chk("pre_fl_level", 32'(level), 10);
`ifdef FIFO_SYNC_ERR_EN
      chk("pre_fl_ovf", 32'(ovf), 1);
`endif
      drive(1, 1, 1, 8'h77);
      step();
      chk("fl_level", 32'(level), 0);
      chk("fl_rempty", 32'(rempty), 1);
      chk("fl_rvalid", 32'(rvalid), 0);
      chk("fl_rdata", 32'(rdata), 32'h85);
`ifdef FIFO_SYNC_ERR_EN
      chk("fl_ovf", 32'(ovf), 0);
`endif

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            afull_thr = 5'($urandom_range(0, 16));
            aempty_thr = 5'($urandom_range(0, 16));
         end
         drive($urandom_range(0, 63) == 0,
               $urandom_range(0, 99) < 55,
               $urandom_range(0, 99) < 50,
               8'($urandom));
         step();
      end

      // asynchronous reset mid-operation
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 0, 8'(8'hC0 + i));
         step();
      end
      drive(0, 1, 1, 8'hC5);
      step();
      drive(0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_level", 32'(level), 0);
      chk("arst_rempty", 32'(rempty), 1);
      chk("arst_rvalid", 32'(rvalid), 0);
      chk("arst_rdata", 32'(rdata), 0);
      chk("arst_raempty", 32'(raempty), 1);
      #1;
      rst_n = 1'b1;
      drive(0, 0, 1, 0);
      step();
      chk("arst_post_rv", 32'(rvalid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
